// File: rtl/rpn_keypad_scanner.sv
// rpn_keypad_scanner: scans a 4x4 active-low matrix keypad, debounces whole scans and
// presents a single accepted key to rpn_stack as key_code plus a level-style intro.
// Optional auto-repeat is built when RPN_KEYPAD_AUTOREPEAT_EN is defined.

module rpn_keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 64,
    parameter int unsigned REPEAT_RATE    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [4:0] key_code,
    output logic       intro
);

    localparam int unsigned    DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]     DebLast = 4'(DEBOUNCE_SCANS);
    localparam logic [4:0]     CodeNop = 5'b10110;

    // Elaboration-time guard on the parameter ranges the scan/repeat timing relies on.
    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
        REPEAT_RATE < 2 || REPEAT_DELAY < REPEAT_RATE) begin : gen_param_check
        $error("rpn_keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        StReleased,
        StPressDeb,
        StPressed,
        StRelDeb
    } state_e;

    // Key index is {column, row}; returns the rpn_stack in_num encoding.
    function automatic logic [4:0] key_to_code(input logic [3:0] k);
        logic [4:0] code;
        code = CodeNop;
        unique case (k)
            4'h0: code = 5'b00001;  // row0 col0 '1'
            4'h1: code = 5'b00100;  // row1 col0 '4'
            4'h2: code = 5'b00111;  // row2 col0 '7'
            4'h3: code = 5'b10100;  // row3 col0 UP
            4'h4: code = 5'b00010;  // row0 col1 '2'
            4'h5: code = 5'b00101;  // row1 col1 '5'
            4'h6: code = 5'b01000;  // row2 col1 '8'
            4'h7: code = 5'b00000;  // row3 col1 '0'
            4'h8: code = 5'b00011;  // row0 col2 '3'
            4'h9: code = 5'b00110;  // row1 col2 '6'
            4'hA: code = 5'b01001;  // row2 col2 '9'
            4'hB: code = 5'b10101;  // row3 col2 DOWN
            4'hC: code = 5'b10000;  // row0 col3 PLUS
            4'hD: code = 5'b10001;  // row1 col3 MINUS
            4'hE: code = 5'b10010;  // row2 col3 BACKS
            4'hF: code = 5'b10011;  // row3 col3 ENTER
            default: code = CodeNop;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Row synchronizer and column scan
    // ------------------------------------------------------------------
    logic [3:0]      row_s1_q, row_s2_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      col_q;
    logic [3:0]      col_n_q;
    logic [15:0]     snap_q;
    logic [15:0]     snap_full;
    logic [1:0]      col_nxt;
    logic            slot_last;
    logic            scan_done;

    // Two-flop synchronizer; rows idle high through the pull-ups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
        end
    end

    // Slot timing and the snapshot as it will look once the current column is folded in.
    always_comb begin
        slot_last = (div_q == DivLast);
        scan_done = slot_last && (col_q == 2'd3);
        col_nxt   = col_q + 2'd1;
        snap_full = snap_q;
        for (int r = 0; r < 4; r++) begin
            snap_full[{col_q, 2'(r)}] = ~row_s2_q[r];
        end
    end

    // Column divider, one-cold column drive and snapshot capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            col_q   <= 2'd0;
            col_n_q <= 4'b1110;
            snap_q  <= '0;
        end else if (slot_last) begin
            div_q   <= '0;
            col_q   <= col_nxt;
            col_n_q <= ~(4'b0001 << col_nxt);
            snap_q  <= snap_full;
        end else begin
            div_q   <= div_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot classification
    // ------------------------------------------------------------------
    logic [4:0] hit_cnt;
    logic [3:0] hit_idx;
    logic       single;
    logic       cand_hit;

    state_e     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] key_code_q, key_code_d;
    logic       intro_q, intro_d;

    // Count set bits and remember the (only meaningful when single) index.
    always_comb begin
        hit_cnt = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                hit_cnt = hit_cnt + 5'd1;
                hit_idx = 4'(i);
            end
        end
        single   = (hit_cnt == 5'd1);
        cand_hit = snap_full[cand_q];
    end

`ifdef RPN_KEYPAD_AUTOREPEAT_EN
    localparam int unsigned    HoldW     = $clog2(REPEAT_DELAY + 1);
    localparam logic [HoldW-1:0] RepDelay  = HoldW'(REPEAT_DELAY);
    localparam logic [HoldW-1:0] RepReload = HoldW'(REPEAT_DELAY - REPEAT_RATE);

    logic [HoldW-1:0] hold_q, hold_d;

    // Held-scan counter for auto-repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    // Next-state and output logic; everything moves only on scan_done.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        key_code_d = key_code_q;
        intro_d    = intro_q;
`ifdef RPN_KEYPAD_AUTOREPEAT_EN
        hold_d     = hold_q;
`endif
        if (scan_done) begin
            unique case (state_q)
                StReleased: begin
                    if (single) begin
                        cand_d = hit_idx;
                        cnt_d  = 4'd1;
                        if (DebLast == 4'd1) begin
                            state_d    = StPressed;
                            key_code_d = key_to_code(hit_idx);
                            intro_d    = 1'b1;
                            cnt_d      = '0;
`ifdef RPN_KEYPAD_AUTOREPEAT_EN
                            hold_d     = '0;
`endif
                        end else begin
                            state_d = StPressDeb;
                        end
                    end
                end
                StPressDeb: begin
                    // Any other key, multiple keys or none restarts the debounce.
                    if (single && (hit_idx == cand_q)) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DebLast) begin
                            state_d    = StPressed;
                            key_code_d = key_to_code(cand_q);
                            intro_d    = 1'b1;
                            cnt_d      = '0;
`ifdef RPN_KEYPAD_AUTOREPEAT_EN
                            hold_d     = '0;
`endif
                        end
                    end else begin
                        state_d = StReleased;
                        cnt_d   = '0;
                    end
                end
                StPressed: begin
                    if (!cand_hit) begin
`ifdef RPN_KEYPAD_AUTOREPEAT_EN
                        hold_d = '0;
`endif
                        if (DebLast == 4'd1) begin
                            state_d = StReleased;
                            intro_d = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            state_d = StRelDeb;
                            cnt_d   = 4'd1;
                        end
                    end else begin
`ifdef RPN_KEYPAD_AUTOREPEAT_EN
                        // One-scan low pulse at REPEAT_DELAY, then every REPEAT_RATE scans.
                        hold_d = hold_q + 1'b1;
                        if (!intro_q) begin
                            intro_d = 1'b1;
                        end
                        if (hold_q + 1'b1 == RepDelay) begin
                            intro_d = 1'b0;
                            hold_d  = RepReload;
                        end
`endif
                    end
                end
                StRelDeb: begin
                    if (!cand_hit) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DebLast) begin
                            state_d = StReleased;
                            intro_d = 1'b0;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = StPressed;
                        intro_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReleased;
            cand_q     <= '0;
            cnt_q      <= '0;
            key_code_q <= CodeNop;
            intro_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            key_code_q <= key_code_d;
            intro_q    <= intro_d;
        end
    end

    assign col_n    = col_n_q;
    assign key_code = key_code_q;
    assign intro    = intro_q;

endmodule

// File: tb/tb_rpn_keypad_scanner.sv
// Self-checking bench for rpn_keypad_scanner: directed scenarios plus random key
// sequences, compared scan by scan against a scan-level behavioural model.

module tb_rpn_keypad_scanner;

    localparam int unsigned SD  = 4;
    localparam int unsigned DEB = 3;
    localparam int unsigned RD  = 8;
    localparam int unsigned RR  = 4;
    localparam int unsigned SCAN_CYC = 4 * SD;

    // Key codes listed row-major as the keypad is labelled: index row*4 + col.
    localparam logic [4:0] KEYMAP [16] = '{
        5'b00001, 5'b00010, 5'b00011, 5'b10000,
        5'b00100, 5'b00101, 5'b00110, 5'b10001,
        5'b00111, 5'b01000, 5'b01001, 5'b10010,
        5'b10100, 5'b00000, 5'b10101, 5'b10011
    };

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [4:0] key_code;
    logic       intro;

    // Pressed keys, bit index = col*4 + row.
    logic [15:0] keys;

    int n_checks;
    int n_fail;

    // Scan-level model state: 0 released, 1 press debounce, 2 pressed, 3 release debounce.
    int         m_state;
    int         m_cand;
    int         m_cnt;
    int         m_hold;
    logic       m_intro;
    logic [4:0] m_code;

    rpn_keypad_scanner #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .row_n   (row_n),
        .col_n   (col_n),
        .key_code(key_code),
        .intro   (intro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to its column when that column is low.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4 + r] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cand  = 0;
        m_cnt   = 0;
        m_hold  = 0;
        m_intro = 1'b0;
        m_code  = 5'b10110;
    endtask

    task automatic model_accept();
        m_state = 2;
        m_code  = KEYMAP[(m_cand % 4) * 4 + (m_cand / 4)];
        m_intro = 1'b1;
        m_hold  = 0;
    endtask

    // Apply the debounce rules to one complete scan of the pressed-key set k.
    task automatic model_scan(input logic [15:0] k);
        int n;
        int idx;
        n   = $countones(k);
        idx = -1;
        for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        case (m_state)
            0: if (n == 1) begin
                m_cand = idx;
                m_cnt  = 1;
                if (m_cnt == DEB) model_accept();
                else m_state = 1;
            end
            1: if (n == 1 && idx == m_cand) begin
                m_cnt++;
                if (m_cnt == DEB) model_accept();
            end else begin
                m_state = 0;
                m_cnt   = 0;
            end
            2: if (!k[m_cand]) begin
                m_hold = 0;
                m_cnt  = 1;
                if (m_cnt == DEB) begin
                    m_state = 0;
                    m_intro = 1'b0;
                    m_cnt   = 0;
                end else m_state = 3;
            end else begin
                m_hold++;
`ifdef RPN_KEYPAD_AUTOREPEAT_EN
                m_intro = !(m_hold >= RD && ((m_hold - RD) % RR) == 0);
`endif
            end
            default: if (!k[m_cand]) begin
                m_cnt++;
                if (m_cnt == DEB) begin
                    m_state = 0;
                    m_intro = 1'b0;
                    m_cnt   = 0;
                end
            end else begin
                m_state = 2;
                m_intro = 1'b1;
                m_hold  = 0;
            end
        endcase
    endtask

    // Hold k for one full scan (called #1 after a scan-done edge) and compare at its end.
    task automatic run_scan(input logic [15:0] k, input string tag);
        keys = k;
        repeat (SCAN_CYC) @(posedge clk);
        #1;
        model_scan(k);
        check_eq({tag, ".intro"}, {15'd0, intro}, {15'd0, m_intro});
        check_eq({tag, ".code"}, {11'd0, key_code}, {11'd0, m_code});
        check_eq({tag, ".col"}, {12'd0, col_n}, 16'h000E);
    endtask

    // Release reset on a falling edge and follow the column walk through the first scan.
    task automatic release_reset();
        logic [3:0] exp_col [3];
        exp_col[0] = 4'b1101;
        exp_col[1] = 4'b1011;
        exp_col[2] = 4'b0111;
        keys = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            repeat (SD) @(posedge clk);
            #1;
            check_eq("col_step", {12'd0, col_n}, {12'd0, exp_col[s]});
        end
        repeat (SD) @(posedge clk);
        #1;
        model_scan('0);
        check_eq("first_scan.col", {12'd0, col_n}, 16'h000E);
        check_eq("first_scan.intro", {15'd0, intro}, {15'd0, m_intro});
    endtask

    initial begin
        int nscan;
        int pick;
        logic [15:0] k;
        n_checks = 0;
        n_fail   = 0;
        keys     = '0;
        rst_n    = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.col", {12'd0, col_n}, 16'h000E);
        check_eq("rst.intro", {15'd0, intro}, 16'h0000);
        check_eq("rst.code", {11'd0, key_code}, 16'h0016);
        release_reset();

        // Clean press and release of '6' (row1 col2).
        repeat (DEB) run_scan(16'h0200, "six");
        check_eq("six.accepted", {11'd0, key_code}, 16'h0006);
        repeat (DEB) run_scan(16'h0000, "six_rel");
        check_eq("six.kept", {11'd0, key_code}, 16'h0006);

        // Bouncy '9' (row2 col2): 2 present, 1 absent, 3 present.
        repeat (2) run_scan(16'h0400, "bounce_a");
        run_scan(16'h0000, "bounce_gap");
        repeat (3) run_scan(16'h0400, "bounce_b");
        check_eq("bounce.code", {11'd0, key_code}, 16'h0009);
        repeat (DEB) run_scan(16'h0000, "bounce_rel");

        // '1' and '2' together, then '2' alone.
        repeat (5) run_scan(16'h0011, "multi");
        check_eq("multi.intro_low", {15'd0, intro}, 16'h0000);
        repeat (DEB) run_scan(16'h0010, "two");
        check_eq("two.code", {11'd0, key_code}, 16'h0002);
        repeat (DEB) run_scan(16'h0000, "two_rel");

        // ENTER held, then '5' added alongside it.
        repeat (DEB) run_scan(16'h8000, "enter");
        repeat (4) run_scan(16'h8020, "enter_plus5");
        check_eq("enter.code", {11'd0, key_code}, 16'h0013);

        // Asynchronous reset while pressed, away from any clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst.intro", {15'd0, intro}, 16'h0000);
        check_eq("async_rst.code", {11'd0, key_code}, 16'h0016);
        check_eq("async_rst.col", {12'd0, col_n}, 16'h000E);
        model_reset();
        #20;
        release_reset();

`ifdef RPN_KEYPAD_AUTOREPEAT_EN
        // UP (row3 col0) held long enough for several repeats.
        repeat (DEB + 20) run_scan(16'h0008, "repeat");
        repeat (DEB) run_scan(16'h0000, "repeat_rel");
`endif

        // Random key sequences: idle, single keys and key pairs held for random lengths.
        for (int seg = 0; seg < 60; seg++) begin
            pick  = int'($urandom_range(0, 99));
            nscan = int'($urandom_range(1, 6));
            k = '0;
            if (pick < 35) begin
                k = '0;
            end else if (pick < 80) begin
                k[$urandom_range(0, 15)] = 1'b1;
            end else begin
                k[$urandom_range(0, 15)] = 1'b1;
                k[$urandom_range(0, 15)] = 1'b1;
            end
            for (int s = 0; s < nscan; s++) run_scan(k, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
